// File: rtl/mvau_weight_sched.sv
// mvau_weight_sched: weight-memory read scheduler for one MVAU PE lane.
// Issues addresses 0..WMEM_DEPTH-1 per vector, with valid/last side-band aligned to the registered read.
module mvau_weight_sched #(
  parameter int SF           = 2,
  parameter int NF           = 2,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int NV_BW        = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic [NV_BW-1:0]        num_vec,
  input  logic                    out_ready,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic                    w_valid,
  output logic                    w_sf_last,
  output logic                    w_nf_last,
  output logic                    w_vec_last,
  output logic                    busy,
  output logic                    done
);
  localparam int SF_BW = SF > 1 ? $clog2(SF) : 1;
  localparam int NF_BW = NF > 1 ? $clog2(NF) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]              state;
  logic [WMEM_ADDR_BW-1:0] issue_addr;
  logic [WMEM_ADDR_BW-1:0] hold_addr;
  logic [SF_BW-1:0]        sf_cnt;
  logic [NF_BW-1:0]        nf_cnt;
  logic [NV_BW-1:0]        vec_cnt;
  logic [NV_BW-1:0]        nv_lat;
  logic                    issue;
  logic                    sf_end;
  logic                    nf_end;
  logic                    vec_end;

  assign issue   = state == RUN && (!w_valid || out_ready);
  assign sf_end  = sf_cnt == SF_BW'(SF - 1);
  assign nf_end  = sf_end && nf_cnt == NF_BW'(NF - 1);
  assign vec_end = nf_end && vec_cnt == nv_lat - NV_BW'(1);
  // Stalled cycles re-read the held address so the registered memory output stays stable.
  assign wmem_addr = issue ? issue_addr : hold_addr;
  assign busy      = state != IDLE;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      issue_addr <= '0;
      hold_addr  <= '0;
      sf_cnt     <= '0;
      nf_cnt     <= '0;
      vec_cnt    <= '0;
      nv_lat     <= '0;
      w_valid    <= 1'b0;
      w_sf_last  <= 1'b0;
      w_nf_last  <= 1'b0;
      w_vec_last <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        hold_addr  <= issue_addr;
        issue_addr <= issue_addr == WMEM_ADDR_BW'(WMEM_DEPTH - 1) ? '0 : issue_addr + WMEM_ADDR_BW'(1);
        sf_cnt     <= sf_end ? '0 : sf_cnt + SF_BW'(1);
        if (sf_end) nf_cnt <= nf_end ? '0 : nf_cnt + NF_BW'(1);
        if (nf_end) vec_cnt <= vec_cnt + NV_BW'(1);
        w_valid    <= 1'b1;
        w_sf_last  <= sf_end;
        w_nf_last  <= nf_end;
        w_vec_last <= vec_end;
        if (vec_end) state <= DRAIN;
      end else if (out_ready) begin
        w_valid    <= 1'b0;
        w_sf_last  <= 1'b0;
        w_nf_last  <= 1'b0;
        w_vec_last <= 1'b0;
      end
      if (state == IDLE && start) begin
        if (num_vec != '0) begin
          state      <= RUN;
          nv_lat     <= num_vec;
          sf_cnt     <= '0;
          nf_cnt     <= '0;
          vec_cnt    <= '0;
          issue_addr <= '0;
        end else begin
          done <= 1'b1;
        end
      end
      if (state == DRAIN && w_valid && out_ready) begin
        state <= IDLE;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mvau_weight_sched.sv
// tb_mvau_weight_sched: randomized and directed checks of mvau_weight_sched against a word-list reference model.
module tb_mvau_weight_sched;
  localparam int SF  = 2;
  localparam int NF  = 2;
  localparam int D   = SF * NF;
  localparam int ABW = 4;
  localparam int NVB = 16;

  typedef struct packed {
    int addr;
    bit sf;
    bit nf;
    bit vl;
  } word_t;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           start = 1'b0;
  logic [NVB-1:0] num_vec = '0;
  logic           out_ready = 1'b0;
  logic [ABW-1:0] wmem_addr;
  logic           w_valid, w_sf_last, w_nf_last, w_vec_last, busy, done;
  logic [7:0]     mem [0:(1<<ABW)-1];
  logic [7:0]     wmem_out;
  int             total = 0;
  int             bad = 0;

  mvau_weight_sched #(.SF(SF), .NF(NF), .WMEM_DEPTH(D), .WMEM_ADDR_BW(ABW), .NV_BW(NVB)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .num_vec(num_vec), .out_ready(out_ready),
    .wmem_addr(wmem_addr), .w_valid(w_valid), .w_sf_last(w_sf_last), .w_nf_last(w_nf_last),
    .w_vec_last(w_vec_last), .busy(busy), .done(done)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) wmem_out <= mem[wmem_addr];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: 3-cycle stall on addr 1, 3: ready + stray start mid-run
  task automatic run(input int nv, input int mode);
    word_t q[$];
    word_t w;
    int k = 0, stall_left = 3, first_v = -1, nwords = nv * D;
    bit got_done = 0, acc = 0, acc_prev = 0, held = 0;
    logic [7:0] hd = '0;
    for (int v = 0; v < nv; v++)
      for (int a = 0; a < D; a++) begin
        w.addr = a;
        w.sf = (a % SF) == SF - 1;
        w.nf = a == D - 1;
        w.vl = (v == nv - 1) && (a == D - 1);
        q.push_back(w);
      end
    @(negedge aclk);
    start = 1'b1;
    num_vec = NVB'(nv);
    out_ready = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    while (!got_done && k < 400) begin
      start = 1'b0;
      if (mode == 1) out_ready = $urandom_range(0, 3) != 0;
      else if (mode == 2) begin
        out_ready = !(w_valid && q.size() > 0 && q[0].addr == 1 && stall_left > 0);
        if (!out_ready) stall_left--;
      end else out_ready = 1'b1;
      if (mode == 3 && k == 2) begin
        start = 1'b1;
        num_vec = NVB'(5);
      end
      #1;
      acc = 0;
      if (done) begin
        got_done = 1;
        chk("done_after_last_accept", int'(acc_prev), 1);
        chk("done_queue_empty", q.size(), 0);
        chk("busy_at_done", int'(busy), 0);
        chk("valid_at_done", int'(w_valid), 0);
        if (mode == 0 || mode == 3) chk("done_cycle", k, nwords + 1);
      end else begin
        chk("busy_in_run", int'(busy), 1);
        if (held) begin
          chk("stall_valid_held", int'(w_valid), 1);
          chk("stall_data_stable", int'(wmem_out), int'(hd));
        end
        if (w_valid) begin
          if (q.size() == 0) chk("extra_word", 1, 0);
          else begin
            if (first_v < 0) begin
              first_v = k;
              chk("first_valid_latency", k, 1);
            end
            chk("data", int'(wmem_out), int'(mem[q[0].addr]));
            chk("sf_last", int'(w_sf_last), int'(q[0].sf));
            chk("nf_last", int'(w_nf_last), int'(q[0].nf));
            chk("vec_last", int'(w_vec_last), int'(q[0].vl));
            if (!out_ready) begin
              chk("stall_addr", int'(wmem_addr), q[0].addr);
              held = 1;
              hd = wmem_out;
            end else begin
              held = 0;
              if (q.size() > 1) chk("next_addr", int'(wmem_addr), q[1].addr);
              void'(q.pop_front());
              acc = 1;
            end
          end
        end else begin
          held = 0;
          if (q.size() > 0) chk("issue_addr", int'(wmem_addr), q[0].addr);
        end
      end
      acc_prev = acc;
      @(negedge aclk);
      k++;
    end
    if (!got_done) chk("done_timeout", 0, 1);
    #1;
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ABW); i++) mem[i] = 8'($urandom_range(0, 255));
    #22 aresetn = 1'b1;
    @(negedge aclk);
    #1;
    chk("rst_valid", int'(w_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(wmem_addr), 0);
    chk("rst_flags", int'({w_sf_last, w_nf_last, w_vec_last}), 0);
    run(1, 0);
    run(3, 0);
    run(1, 2);
    run(2, 2);
    // zero-length run
    @(negedge aclk);
    start = 1'b1;
    num_vec = '0;
    @(negedge aclk);
    start = 1'b0;
    #1;
    chk("nv0_done", int'(done), 1);
    chk("nv0_busy", int'(busy), 0);
    chk("nv0_valid", int'(w_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      #1;
      chk("nv0_quiet", int'({w_valid, busy, done}), 0);
    end
    run(1, 3);
    // asynchronous reset mid-run after two words
    @(negedge aclk);
    start = 1'b1;
    num_vec = NVB'(1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      start = 1'b0;
    end
    #1;
    chk("pre_rst_valid", int'(w_valid), 1);
    chk("pre_rst_addr", int'(wmem_addr), 2);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_valid", int'(w_valid), 0);
    chk("arst_addr", int'(wmem_addr), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_flags", int'({w_sf_last, w_nf_last, w_vec_last, done}), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      chk("post_rst_quiet", int'({w_valid, busy, done}), 0);
    end
    run(1, 0);
    for (int i = 0; i < 6; i++) run($urandom_range(1, 4), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
